// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle processor control FSM.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND = 4'b0010, OP_OR = 4'b0011,
    OP_ADDI = 4'b0100, OP_ORI  = 4'b0101, OP_LW  = 4'b0110, OP_SW = 4'b0111,
    OP_BEQ  = 4'b1000, OP_J    = 4'b1001, OP_HALT = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_HALT
  } cls_t;

  localparam logic [1:0] EXT_ZERO16 = 2'b00;
  localparam logic [1:0] EXT_SIGN16 = 2'b01;
  localparam logic [1:0] EXT_SIGN20 = 2'b10;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] ext_sel;
    alu_op_t    alu_op;
    cls_t       cls;
    logic       imm;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: extender select, ALU op, instruction class, illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '{ext_sel: EXT_ZERO16, alu_op: ALU_ADD, cls: CLS_ALU, imm: 1'b0, illegal: 1'b0};
    case (op)
      OP_ADD:  dec.alu_op = ALU_ADD;
      OP_SUB:  dec.alu_op = ALU_SUB;
      OP_AND:  dec.alu_op = ALU_AND;
      OP_OR:   dec.alu_op = ALU_OR;
      OP_ADDI: begin dec.ext_sel = EXT_SIGN16; dec.imm = 1'b1; end
      OP_ORI:  begin dec.alu_op = ALU_OR; dec.imm = 1'b1; end
      OP_LW:   begin dec.ext_sel = EXT_SIGN16; dec.imm = 1'b1; dec.cls = CLS_LOAD; end
      OP_SW:   begin dec.ext_sel = EXT_SIGN16; dec.imm = 1'b1; dec.cls = CLS_STORE; end
      OP_BEQ:  begin dec.ext_sel = EXT_SIGN20; dec.alu_op = ALU_SUB; dec.cls = CLS_BRANCH; end
      OP_J:    begin dec.ext_sel = EXT_SIGN20; dec.cls = CLS_JUMP; end
      OP_HALT: dec.cls = CLS_HALT;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing with memory
// handshake timeout. Ack- and zero-dependent pulses are combinational; the rest registered.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic [1:0]  ext_sel_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        rf_we_o,
  output logic        wb_sel_o,
  output logic        halt_o,
  output logic        fault_o
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state, nxt;
  logic [3:0]    op;
  logic [3:0]    op_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  dec_t          dec;
  logic          unused_ok;

  assign unused_ok = ^instr_i[27:0];

  // In DECODE the decoder sees the incoming opcode; elsewhere the latched one.
  assign op_nxt  = (state == DECODE) ? instr_i[31:28] : op;
  assign timeout = !mem_ack_i && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  ctrl_decode u_dec (.op(op_nxt), .dec(dec));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_i) nxt = FETCH;
      FETCH:   if (mem_ack_i) nxt = DECODE;
               else if (timeout) nxt = FAULT;
      DECODE:  if (dec.illegal) nxt = FAULT;
               else if (dec.cls == CLS_HALT) nxt = HALTED;
               else nxt = EXEC;
      EXEC:    case (dec.cls)
                 CLS_LOAD, CLS_STORE:  nxt = MEM;
                 CLS_BRANCH, CLS_JUMP: nxt = FETCH;
                 default:              nxt = WB;
               endcase
      MEM:     if (mem_ack_i) nxt = (dec.cls == CLS_STORE) ? FETCH : WB;
               else if (timeout) nxt = FAULT;
      WB:      nxt = FETCH;
      HALTED:  if (start_i) nxt = FETCH;
      FAULT:   nxt = FAULT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ir_we_o  = (state == FETCH) && mem_ack_i;
    pc_we_o  = ir_we_o;
    pc_src_o = PC_SRC_INC;
    if (state == EXEC && dec.cls == CLS_BRANCH) begin
      pc_src_o = PC_SRC_BRANCH;
      pc_we_o  = zero_i;
    end else if (state == EXEC && dec.cls == CLS_JUMP) begin
      pc_src_o = PC_SRC_JUMP;
      pc_we_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      op        <= 4'b0000;
      ext_sel_o <= EXT_ZERO16;
      alu_op_o  <= ALU_ADD;
      wait_cnt  <= '0;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      alu_src_o <= 1'b0;
      rf_we_o   <= 1'b0;
      wb_sel_o  <= 1'b0;
      halt_o    <= 1'b0;
      fault_o   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == DECODE) begin
        op        <= op_nxt;
        ext_sel_o <= dec.ext_sel;
        alu_op_o  <= dec.alu_op;
      end
      // FETCH/MEM are only ever entered from a different state, so a change clears.
      if (nxt != state)                     wait_cnt <= '0;
      else if (state == FETCH || state == MEM) wait_cnt <= wait_cnt + 1'b1;
      mem_req_o <= (nxt == FETCH) || (nxt == MEM);
      mem_we_o  <= (nxt == MEM) && (dec.cls == CLS_STORE);
      alu_src_o <= (nxt == EXEC) && dec.imm;
      rf_we_o   <= (nxt == WB);
      wb_sel_o  <= (nxt == WB) && (dec.cls == CLS_LOAD);
      halt_o    <= (nxt == HALTED);
      fault_o   <= (nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequences with hand-computed control outputs.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic        zero;
  logic        ack;
  logic        mem_req, mem_we, ir_we, pc_we, alu_src, rf_we, wb_sel, halt, fault;
  logic [1:0]  pc_src, ext_sel;
  logic [2:0]  alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_i(instr), .zero_i(zero),
    .mem_ack_i(ack), .mem_req_o(mem_req), .mem_we_o(mem_we), .ir_we_o(ir_we),
    .pc_we_o(pc_we), .pc_src_o(pc_src), .ext_sel_o(ext_sel), .alu_op_o(alu_op),
    .alu_src_o(alu_src), .rf_we_o(rf_we), .wb_sel_o(wb_sel), .halt_o(halt),
    .fault_o(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; instr = '0; zero = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // IDLE -> FETCH
  task automatic begin_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From FETCH entry: n cycles without ack, then ack; returns in DECODE.
  task automatic fetch_instr(input logic [31:0] ins, input int n);
    repeat (n) tick();
    instr = ins;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; instr = '0; zero = 1'b0; ack = 1'b0;
    #2;
    n_checks++;
    if ({mem_req, mem_we, ir_we, pc_we, pc_src, ext_sel, alu_op, alu_src, rf_we, wb_sel, halt, fault} !== 17'h0) begin
      $display("FAIL reset_outputs: got %h expected 0",
               {mem_req, mem_we, ir_we, pc_we, pc_src, ext_sel, alu_op, alu_src, rf_we, wb_sel, halt, fault});
      n_fail++;
    end
    do_reset();
    tick();
    n_checks++;
    if (mem_req !== 1'b0) begin $display("FAIL idle_no_start: mem_req got %b expected 0", mem_req); n_fail++; end
  endtask

  task automatic test_addi();
    do_reset();
    begin_fetch();
    n_checks++;
    if ({mem_req, mem_we} !== 2'b10) begin $display("FAIL fetch_req: got %b expected 10", {mem_req, mem_we}); n_fail++; end
    instr = 32'h412F_FFFF;
    ack = 1'b1;
    #1;
    n_checks++;
    if ({ir_we, pc_we, pc_src} !== 4'b1100) begin $display("FAIL fetch_ack_pulses: got %b expected 1100", {ir_we, pc_we, pc_src}); n_fail++; end
    tick(); ack = 1'b0;                       // DECODE
    n_checks++;
    if ({ir_we, pc_we, rf_we} !== 3'b000) begin $display("FAIL decode_quiet: got %b expected 000", {ir_we, pc_we, rf_we}); n_fail++; end
    tick();                                   // EXEC
    n_checks++;
    if ({ext_sel, alu_src, alu_op} !== 6'b01_1_000) begin $display("FAIL addi_exec: got %b expected 011000", {ext_sel, alu_src, alu_op}); n_fail++; end
    tick();                                   // WB
    n_checks++;
    if ({rf_we, wb_sel} !== 2'b10) begin $display("FAIL addi_wb: got %b expected 10", {rf_we, wb_sel}); n_fail++; end
    tick();                                   // FETCH
    n_checks++;
    if ({rf_we, mem_req} !== 2'b01) begin $display("FAIL addi_refetch: got %b expected 01", {rf_we, mem_req}); n_fail++; end
    // ORI back-to-back: zero-extend, OR, immediate operand
    fetch_instr(32'h5120_00FF, 0);
    tick();
    n_checks++;
    if ({ext_sel, alu_src, alu_op} !== 6'b00_1_011) begin $display("FAIL ori_exec: got %b expected 001011", {ext_sel, alu_src, alu_op}); n_fail++; end
    // SUB R-type after ORI: register operand, SUB
    tick(); tick();
    fetch_instr(32'h1123_0000, 0);
    tick();
    n_checks++;
    if ({ext_sel, alu_src, alu_op} !== 6'b00_0_001) begin $display("FAIL sub_exec: got %b expected 000001", {ext_sel, alu_src, alu_op}); n_fail++; end
  endtask

  task automatic test_lw_sw();
    do_reset();
    begin_fetch();
    fetch_instr(32'h6123_0004, 3);
    tick();                                   // EXEC
    n_checks++;
    if ({ext_sel, alu_src, alu_op} !== 6'b01_1_000) begin $display("FAIL lw_exec: got %b expected 011000", {ext_sel, alu_src, alu_op}); n_fail++; end
    tick();                                   // MEM
    n_checks++;
    if ({mem_req, mem_we} !== 2'b10) begin $display("FAIL lw_mem_req: got %b expected 10", {mem_req, mem_we}); n_fail++; end
    repeat (3) tick();
    ack = 1'b1;
    #1;
    n_checks++;
    if ({rf_we, ir_we, mem_req} !== 3'b001) begin $display("FAIL lw_mem_ack: got %b expected 001", {rf_we, ir_we, mem_req}); n_fail++; end
    tick(); ack = 1'b0;                       // WB
    n_checks++;
    if ({rf_we, wb_sel, mem_req} !== 3'b110) begin $display("FAIL lw_wb: got %b expected 110", {rf_we, wb_sel, mem_req}); n_fail++; end
    tick();                                   // FETCH
    fetch_instr(32'h7123_0008, 3);
    tick(); tick();                           // MEM
    n_checks++;
    if ({mem_req, mem_we} !== 2'b11) begin $display("FAIL sw_mem_req: got %b expected 11", {mem_req, mem_we}); n_fail++; end
    repeat (3) tick();
    ack = 1'b1;
    tick(); ack = 1'b0;                       // back to FETCH, no WB
    n_checks++;
    if ({mem_req, mem_we, rf_we} !== 3'b100) begin $display("FAIL sw_done: got %b expected 100", {mem_req, mem_we, rf_we}); n_fail++; end
  endtask

  task automatic test_branch_jump();
    do_reset();
    begin_fetch();
    fetch_instr(32'h8120_0010, 0);
    tick();                                   // EXEC
    zero = 1'b1;
    #1;
    n_checks++;
    if ({pc_we, pc_src, ext_sel, alu_op} !== 8'b1_01_10_001) begin $display("FAIL beq_taken: got %b expected 10110001", {pc_we, pc_src, ext_sel, alu_op}); n_fail++; end
    tick(); zero = 1'b0;                      // FETCH
    n_checks++;
    if ({mem_req, rf_we} !== 2'b10) begin $display("FAIL beq_refetch: got %b expected 10", {mem_req, rf_we}); n_fail++; end
    fetch_instr(32'h8120_0010, 0);
    tick();
    #1;
    n_checks++;
    if (pc_we !== 1'b0) begin $display("FAIL beq_not_taken: pc_we got %b expected 0", pc_we); n_fail++; end
    tick();
    fetch_instr(32'h9000_0100, 0);
    tick();
    #1;
    n_checks++;
    if ({pc_we, pc_src, ext_sel} !== 5'b1_10_10) begin $display("FAIL jump_exec: got %b expected 11010", {pc_we, pc_src, ext_sel}); n_fail++; end
  endtask

  task automatic test_illegal();
    do_reset();
    begin_fetch();
    fetch_instr(32'hA000_0000, 0);
    n_checks++;
    if (fault !== 1'b0) begin $display("FAIL illegal_decode: fault got %b expected 0", fault); n_fail++; end
    tick();
    n_checks++;
    if ({fault, ir_we, pc_we, rf_we, mem_req} !== 5'b10000) begin $display("FAIL illegal_fault: got %b expected 10000", {fault, ir_we, pc_we, rf_we, mem_req}); n_fail++; end
    start = 1'b1; ack = 1'b1;
    repeat (3) tick();
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if ({fault, mem_req, ir_we} !== 3'b100) begin $display("FAIL fault_sticky: got %b expected 100", {fault, mem_req, ir_we}); n_fail++; end
    do_reset();
    n_checks++;
    if (fault !== 1'b0) begin $display("FAIL fault_reset: fault got %b expected 0", fault); n_fail++; end
  endtask

  task automatic test_timeout();
    do_reset();
    begin_fetch();
    instr = 32'h0123_0000;
    repeat (15) tick();
    ack = 1'b1;
    #1;
    n_checks++;
    if (ir_we !== 1'b1) begin $display("FAIL ack_limit_cycle: ir_we got %b expected 1", ir_we); n_fail++; end
    tick(); ack = 1'b0;                       // DECODE
    n_checks++;
    if ({fault, mem_req} !== 2'b00) begin $display("FAIL ack_limit_decode: got %b expected 00", {fault, mem_req}); n_fail++; end
    repeat (3) tick();                        // EXEC, WB, FETCH
    repeat (15) tick();
    n_checks++;
    if ({fault, mem_req} !== 2'b01) begin $display("FAIL timeout_last_wait: got %b expected 01", {fault, mem_req}); n_fail++; end
    tick();
    n_checks++;
    if ({fault, mem_req} !== 2'b10) begin $display("FAIL timeout_fault: got %b expected 10", {fault, mem_req}); n_fail++; end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    begin_fetch();
    fetch_instr(32'h6123_0004, 0);
    tick(); tick();                           // MEM
    n_checks++;
    if (mem_req !== 1'b1) begin $display("FAIL mid_mem_req: got %b expected 1", mem_req); n_fail++; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, rf_we} !== 3'b000) begin $display("FAIL async_reset_drop: got %b expected 000", {mem_req, mem_we, rf_we}); n_fail++; end
    ack = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ack = 1'b0;
    tick();
    n_checks++;
    if ({mem_req, rf_we, wb_sel} !== 3'b000) begin $display("FAIL reset_no_completion: got %b expected 000", {mem_req, rf_we, wb_sel}); n_fail++; end
  endtask

  task automatic test_halt();
    do_reset();
    begin_fetch();
    fetch_instr(32'hF000_0000, 0);
    tick();
    n_checks++;
    if ({halt, mem_req} !== 2'b10) begin $display("FAIL halt_enter: got %b expected 10", {halt, mem_req}); n_fail++; end
    tick();
    n_checks++;
    if (halt !== 1'b1) begin $display("FAIL halt_hold: got %b expected 1", halt); n_fail++; end
    begin_fetch();
    n_checks++;
    if ({halt, mem_req} !== 2'b01) begin $display("FAIL halt_resume: got %b expected 01", {halt, mem_req}); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_sw();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
